timer_slave: RTL and testbench
==============================

# timer_slave

Memory-mapped 16-bit timer that sits as a responder on the CPU data bus, behind the BUS address decoder. It answers CPU register reads and writes, runs a prescaled up-counter with compare, auto-reload and one-shot modes, and drives the level `irq_timer` line into the CPU interrupt vector (bit 0).

## Interface
- `CPU_WIDTH`, 16: data and counter width.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sel` in 1: BUS decode hit for this block's address window.
- `addr` in 3: register offset, taken from `mem_addr[2:0]`.
- `ctrl` in 1: 1 = write, 0 = read. Same meaning as `mem_ctrl`.
- `wdata` in CPU_WIDTH: write data.
- `rdata` out CPU_WIDTH: read data. Combinational. All zeros when `sel`=0, so BUS can OR-combine responders.
- `irq_timer` out 1: interrupt request, level.
- `pwm_out` out 1: present only with `TIMER_PWM_EN`.

## Operation
- Register map:
  - 0 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE (irq enable), bit15 PEND (read; write 1 clears). Other bits read 0.
  - 1 PSC: prescaler reload value.
  - 2 CMP: compare/period value.
  - 3 CNT: read returns the live counter; a write loads it.
  - 4 DUTY: PWM threshold; see Configuration.
  - 5–7: read 0, writes ignored.
- Write strobe is `sel & ctrl`; the register updates on that rising edge.
- A read has no side effects.
- Prescaler:
  - `psc_cnt` counts 0..PSC while EN=1.
  - `tick` fires when `psc_cnt`==PSC; `psc_cnt` then returns to 0.
  - With EN=0, `psc_cnt` holds at 0.
- On each tick:
  - If CNT==CMP: set PEND, then
    - AR=1: CNT←0.
    - AR=0 (one-shot): CNT holds and EN←0.
  - Otherwise CNT←CNT+1, 16-bit wrap. A CNT loaded above CMP counts through FFFF→0 and up to CMP.
- `irq_timer` = PEND & IE.
- Auto-reload period = (PSC+1)·(CMP+1) cycles.

## Timing
- Reset values: CTRL=0, PSC=0, CMP=FFFF, CNT=0, DUTY=0, `psc_cnt`=0, `irq_timer`=0, `pwm_out`=0.
- Reset mid-count aborts immediately and asynchronously.
- EN write 0→1 at edge T: `psc_cnt` is cleared. The first tick is at edge T+PSC+1.
- PSC=0: CNT advances every cycle.
- `irq_timer` rises in the cycle after the edge that sets PEND. It falls the cycle after the write-1-clear edge.
- Simultaneous events:
  - PEND set and write-1-clear on the same edge: set wins.
  - CNT write and tick on the same edge: the write wins, and `psc_cnt` is cleared.
  - A PSC write clears `psc_cnt`.
  - A CTRL write of EN=1 on the same edge as a one-shot completion: the write wins, so the timer stays enabled.
- A CMP write takes effect for the next tick comparison.

## Configuration
- Macro: `TIMER_PWM_EN`.
- Defined:
  - DUTY register is implemented at offset 4.
  - `pwm_out` port exists, registered: `pwm_out` ← EN & (CNT < DUTY).
  - DUTY=0 gives a constant 0.
  - DUTY>CMP gives a constant 1 while EN=1.
- Undefined:
  - No `pwm_out` port and no DUTY flops.
  - Offset 4 reads 0 and writes are ignored.

## Structure
- Package `timer_pkg`:
  - Register offsets `TMR_CTRL`, `TMR_PSC`, `TMR_CMP`, `TMR_CNT`, `TMR_DUTY`.
  - CTRL bit indices `CTRL_EN`, `CTRL_AR`, `CTRL_IE`, `CTRL_PEND`.
  - CMP reset constant.
- Sub-module `timer_prescaler`:
  - Inputs: `clk`, `rst_n`, `en`, `clr`, `psc`.
  - Output: `tick`.
  - Top-level holds the register file, counter/compare logic, read mux and PWM.

## Test plan
- Reset, then read all offsets → CTRL=0000, PSC=0000, CMP=FFFF, CNT=0000; `irq_timer`=0.
- PSC=3, CMP=4, CTRL=0x0007 → PEND and `irq_timer` rise every 20 cycles. CNT sequence is 0,1,2,3,4,0, each value held 4 cycles.
- PSC=0, CMP=2, CTRL=0x0005 (one-shot) → PEND set at the third tick. CNT holds 2, CTRL reads 0x8004, and the counter stays stopped.
- Write 0x8000 to CTRL on the same edge PEND is set → PEND remains 1. A later clear write returns `irq_timer` to 0 one cycle after.
- CNT write 0xFFFE with CMP=1, PSC=0, AR=1 → CNT runs FFFE, FFFF, 0000, 0001, then PEND. A CNT write on a tick edge loads the written value.
- With `TIMER_PWM_EN`: CMP=9, DUTY=3, PSC=0, AR=1 → `pwm_out` high 3 of every 10 cycles. Without the macro, a DUTY read returns 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register offsets, CTRL bit positions and reset constants for the bus timer.
package timer_pkg;

    localparam logic [2:0] TMR_CTRL = 3'd0;
    localparam logic [2:0] TMR_PSC  = 3'd1;
    localparam logic [2:0] TMR_CMP  = 3'd2;
    localparam logic [2:0] TMR_CNT  = 3'd3;
    localparam logic [2:0] TMR_DUTY = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_IE   = 2;
    localparam int CTRL_PEND = 15;

    localparam logic [15:0] CMP_RESET = 16'hFFFF;

    typedef struct packed {
        logic pend;
        logic ie;
        logic ar;
        logic en;
    } ctrl_t;

    // Places the control flags at their architectural bit positions; unused bits read 0.
    function automatic logic [15:0] pack_ctrl(input ctrl_t c);
        logic [15:0] r;
        r            = '0;
        r[CTRL_EN]   = c.en;
        r[CTRL_AR]   = c.ar;
        r[CTRL_IE]   = c.ie;
        r[CTRL_PEND] = c.pend;
        return r;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..psc while enabled and pulses tick on the terminal count.
module timer_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] psc,
    output logic         tick
);

    logic [W-1:0] psc_cnt;

    assign tick = en & (psc_cnt == psc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
        end else if (clr || !en || tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + W'(1);
        end
    end

endmodule

// File: rtl/timer_slave.sv
// Memory-mapped 16-bit timer responder with compare, auto-reload and one-shot modes.
// Optional PWM output and DUTY register are built when TIMER_PWM_EN is defined.
module timer_slave
    import timer_pkg::*;
#(
    parameter int CPU_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel,
    input  logic [2:0]           addr,
    input  logic                 ctrl,
    input  logic [CPU_WIDTH-1:0] wdata,
    output logic [CPU_WIDTH-1:0] rdata,
    output logic                 irq_timer
`ifdef TIMER_PWM_EN
    ,
    output logic                 pwm_out
`endif
);

    ctrl_t                ctrl_reg;
    logic [CPU_WIDTH-1:0] psc_reg;
    logic [CPU_WIDTH-1:0] cmp_reg;
    logic [CPU_WIDTH-1:0] cnt_reg;

    logic wr;
    logic ctrl_wr;
    logic psc_wr;
    logic cmp_wr;
    logic cnt_wr;
    logic psc_clr;
    logic tick;
    logic tick_eff;
    logic hit;

    assign wr      = sel & ctrl;
    assign ctrl_wr = wr && (addr == TMR_CTRL);
    assign psc_wr  = wr && (addr == TMR_PSC);
    assign cmp_wr  = wr && (addr == TMR_CMP);
    assign cnt_wr  = wr && (addr == TMR_CNT);

    // Restart the prescale phase on PSC/CNT loads and on an EN 0->1 transition.
    assign psc_clr = psc_wr | cnt_wr | (ctrl_wr & wdata[CTRL_EN] & ~ctrl_reg.en);

    timer_prescaler #(.W(CPU_WIDTH)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl_reg.en),
        .clr   (psc_clr),
        .psc   (psc_reg),
        .tick  (tick)
    );

    // A CNT load on a tick edge replaces that tick's whole effect.
    assign tick_eff = tick & ~cnt_wr;
    assign hit      = tick_eff && (cnt_reg == cmp_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg <= '0;
        end else begin
            if (hit) begin
                ctrl_reg.pend <= 1'b1;
            end else if (ctrl_wr && wdata[CTRL_PEND]) begin
                ctrl_reg.pend <= 1'b0;
            end
            if (ctrl_wr) begin
                ctrl_reg.en <= wdata[CTRL_EN];
                ctrl_reg.ar <= wdata[CTRL_AR];
                ctrl_reg.ie <= wdata[CTRL_IE];
            end else if (hit && !ctrl_reg.ar) begin
                ctrl_reg.en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_reg <= '0;
            cmp_reg <= CPU_WIDTH'(CMP_RESET);
        end else begin
            if (psc_wr) psc_reg <= wdata;
            if (cmp_wr) cmp_reg <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_wr) begin
            cnt_reg <= wdata;
        end else if (hit) begin
            if (ctrl_reg.ar) cnt_reg <= '0;
        end else if (tick_eff) begin
            cnt_reg <= cnt_reg + CPU_WIDTH'(1);
        end
    end

    assign irq_timer = ctrl_reg.pend & ctrl_reg.ie;

`ifdef TIMER_PWM_EN
    logic [CPU_WIDTH-1:0] duty_reg;
    logic                 duty_wr;

    assign duty_wr = wr && (addr == TMR_DUTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_reg <= '0;
            pwm_out  <= 1'b0;
        end else begin
            if (duty_wr) duty_reg <= wdata;
            pwm_out <= ctrl_reg.en & (cnt_reg < duty_reg);
        end
    end
`endif

    // Unselected reads return zero so the bus can OR responders together.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                TMR_CTRL: rdata = CPU_WIDTH'(pack_ctrl(ctrl_reg));
                TMR_PSC:  rdata = psc_reg;
                TMR_CMP:  rdata = cmp_reg;
                TMR_CNT:  rdata = cnt_reg;
`ifdef TIMER_PWM_EN
                TMR_DUTY: rdata = duty_reg;
`endif
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_slave.sv
// Directed self-checking bench for timer_slave; PWM steps build only with TIMER_PWM_EN.
module tb_timer_slave;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [2:0]  addr;
    logic        ctrl;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        irq_timer;
`ifdef TIMER_PWM_EN
    logic        pwm_out;
`endif

    int checks = 0;
    int errors = 0;

    timer_slave #(.CPU_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .addr      (addr),
        .ctrl      (ctrl),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq_timer (irq_timer)
`ifdef TIMER_PWM_EN
        ,
        .pwm_out   (pwm_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        sel = 1'b1; ctrl = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; ctrl = 1'b0; wdata = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] d;
        sel = 1'b1; ctrl = 1'b0; addr = a;
        #1;
        d = rdata;
        sel = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] d;
        int          highs;
        logic [9:0]  pat;

        rst_n = 1'b0; sel = 1'b0; ctrl = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);

        // Reset state
        chk_reg("rst_ctrl", 3'd0, 16'h0000);
        chk_reg("rst_psc",  3'd1, 16'h0000);
        chk_reg("rst_cmp",  3'd2, 16'hFFFF);
        chk_reg("rst_cnt",  3'd3, 16'h0000);
        chk("rst_irq", {15'd0, irq_timer}, 16'h0000);

        // Auto-reload, PSC=3 CMP=4: period 20 cycles
        bus_wr(3'd1, 16'd3);
        bus_wr(3'd2, 16'd4);
        bus_wr(3'd0, 16'h0007);
        chk_reg("ar_cnt_k0", 3'd3, 16'd0);
        step(3);  chk_reg("ar_cnt_k3", 3'd3, 16'd0);
        step(1);  chk_reg("ar_cnt_k4", 3'd3, 16'd1);
        step(11); chk_reg("ar_cnt_k15", 3'd3, 16'd3);
        step(1);  chk_reg("ar_cnt_k16", 3'd3, 16'd4);
        step(3);  chk_reg("ar_cnt_k19", 3'd3, 16'd4);
        chk("ar_irq_k19", {15'd0, irq_timer}, 16'd0);
        step(1);  chk_reg("ar_cnt_k20", 3'd3, 16'd0);
        chk("ar_irq_k20", {15'd0, irq_timer}, 16'd1);
        chk_reg("ar_ctrl_k20", 3'd0, 16'h8007);
        bus_wr(3'd0, 16'h8007);
        chk("ar_irq_clr", {15'd0, irq_timer}, 16'd0);
        chk_reg("ar_ctrl_clr", 3'd0, 16'h0007);
        step(18); chk("ar_irq_k39", {15'd0, irq_timer}, 16'd0);
        chk_reg("ar_cnt_k39", 3'd3, 16'd4);
        step(1);  chk("ar_irq_k40", {15'd0, irq_timer}, 16'd1);
        bus_wr(3'd0, 16'h8000);

        // One-shot, PSC=0 CMP=2
        bus_wr(3'd3, 16'd0);
        bus_wr(3'd1, 16'd0);
        bus_wr(3'd2, 16'd2);
        bus_wr(3'd0, 16'h0005);
        chk_reg("os_ctrl_k0", 3'd0, 16'h0005);
        step(2); chk_reg("os_cnt_k2", 3'd3, 16'd2);
        step(1); chk_reg("os_cnt_k3", 3'd3, 16'd2);
        chk_reg("os_ctrl_k3", 3'd0, 16'h8004);
        chk("os_irq_k3", {15'd0, irq_timer}, 16'd1);
        step(3); chk_reg("os_cnt_k6", 3'd3, 16'd2);
        chk_reg("os_ctrl_k6", 3'd0, 16'h8004);

        // PEND set and write-1-clear on the same edge
        bus_wr(3'd0, 16'h8000);
        bus_wr(3'd3, 16'd0);
        bus_wr(3'd0, 16'h0007);
        step(2); chk_reg("race_cnt_k2", 3'd3, 16'd2);
        bus_wr(3'd0, 16'h8007);
        chk_reg("race_ctrl", 3'd0, 16'h8007);
        chk("race_irq", {15'd0, irq_timer}, 16'd1);
        chk_reg("race_cnt", 3'd3, 16'd0);
        bus_wr(3'd0, 16'h8007);
        chk("race_irq_clr", {15'd0, irq_timer}, 16'd0);
        chk_reg("race_cnt_k4", 3'd3, 16'd1);
        bus_wr(3'd0, 16'h8000);

        // Wrap through FFFF with CMP=1, then CNT write on a tick edge
        bus_wr(3'd2, 16'd1);
        bus_wr(3'd3, 16'hFFFE);
        bus_wr(3'd0, 16'h0003);
        chk_reg("wrap_k0", 3'd3, 16'hFFFE);
        step(1); chk_reg("wrap_k1", 3'd3, 16'hFFFF);
        step(1); chk_reg("wrap_k2", 3'd3, 16'h0000);
        step(1); chk_reg("wrap_k3", 3'd3, 16'h0001);
        chk_reg("wrap_ctrl_k3", 3'd0, 16'h0003);
        step(1); chk_reg("wrap_ctrl_k4", 3'd0, 16'h8003);
        chk_reg("wrap_cnt_k4", 3'd3, 16'h0000);
        chk("wrap_irq_ie0", {15'd0, irq_timer}, 16'd0);
        bus_wr(3'd3, 16'h1234);
        chk_reg("cntwr_k5", 3'd3, 16'h1234);
        step(1); chk_reg("cntwr_k6", 3'd3, 16'h1235);
        bus_wr(3'd0, 16'h8000);

        // CTRL EN=1 write on the one-shot completion edge keeps the timer running
        bus_wr(3'd2, 16'd2);
        bus_wr(3'd3, 16'd0);
        bus_wr(3'd0, 16'h0001);
        step(2); chk_reg("osre_cnt_k2", 3'd3, 16'd2);
        bus_wr(3'd0, 16'h0001);
        chk_reg("osre_ctrl_k3", 3'd0, 16'h8001);
        step(1); chk_reg("osre_ctrl_k4", 3'd0, 16'h8000);
        chk_reg("osre_cnt_k4", 3'd3, 16'd2);

        // Unmapped offsets, unselected read, DUTY
        bus_wr(3'd5, 16'hABCD);
        chk_reg("addr5", 3'd5, 16'h0000);
        chk_reg("addr7", 3'd7, 16'h0000);
        sel = 1'b0; ctrl = 1'b0; addr = 3'd2;
        #1 d = rdata;
        chk("unsel_rdata", d, 16'h0000);
        bus_wr(3'd4, 16'd3);
`ifdef TIMER_PWM_EN
        chk_reg("duty_rd", 3'd4, 16'd3);
        bus_wr(3'd0, 16'h8000);
        bus_wr(3'd2, 16'd9);
        bus_wr(3'd3, 16'd0);
        bus_wr(3'd0, 16'h0003);
        chk("pwm_k0", {15'd0, pwm_out}, 16'd0);
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            pat[k] = pwm_out;
        end
        chk("pwm_pattern", {6'd0, pat}, 16'h0007);
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (pwm_out) highs++;
        end
        chk("pwm_highs", 16'(highs), 16'd3);
        bus_wr(3'd0, 16'h8000);
        step(1);
        chk("pwm_off", {15'd0, pwm_out}, 16'd0);
`else
        chk_reg("duty_absent", 3'd4, 16'h0000);
`endif

        // Asynchronous reset while counting
        bus_wr(3'd2, 16'h00FF);
        bus_wr(3'd3, 16'h0010);
        bus_wr(3'd0, 16'h0007);
        step(3); chk_reg("arst_pre_cnt", 3'd3, 16'h0013);
        #2 rst_n = 1'b0;
        chk_reg("arst_cnt",  3'd3, 16'h0000);
        chk_reg("arst_ctrl", 3'd0, 16'h0000);
        chk_reg("arst_cmp",  3'd2, 16'hFFFF);
        chk("arst_irq", {15'd0, irq_timer}, 16'd0);
        rst_n = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
